// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU): shift-add multiply, restoring divide, fixed WIDTH+1 latency.
// Optional signed support is enabled by defining MDU_SIGNED_EN; otherwise all operations are unsigned.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  state_t state, next_state;

  logic               op_div;
  logic [WIDTH-1:0]   a_orig, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;

`ifdef MDU_SIGNED_EN
  logic neg_a, neg_res, sa_in, sb_in;
  assign sa_in    = Op[1] & A[WIDTH-1];
  assign sb_in    = Op[1] & B[WIDTH-1];
  assign mag_a_in = sa_in ? -A : A;
  assign mag_b_in = sb_in ? -B : B;
  assign prod     = neg_res ? -acc : acc;
  assign quo      = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rmd      = neg_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
`else
  logic unused_op_sign;
  assign unused_op_sign = Op[1];
  assign mag_a_in = A;
  assign mag_b_in = B;
  assign prod     = acc;
  assign quo      = acc[WIDTH-1:0];
  assign rmd      = rem[WIDTH-1:0];
`endif

  // Multiply adds the multiplicand into the high half when the current multiplier bit is set.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
  // Divide: the dividend lives in acc's low half and shifts out MSB-first while quotient bits shift in.
  assign div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};

  assign dbg_state = state;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (Start) next_state = Op[0] ? DIV : MUL;
      MUL:  if (cnt == CW'(1)) next_state = FIX;
      DIV:  if (cnt == CW'(1)) next_state = FIX;
      FIX:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
      op_div  <= 1'b0;
      a_orig  <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      rem     <= '0;
      cnt     <= '0;
`ifdef MDU_SIGNED_EN
      neg_a   <= 1'b0;
      neg_res <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      Busy <= (next_state != IDLE);
      case (state)
        IDLE: if (Start) begin
          op_div <= Op[0];
          a_orig <= A;
          mag_a  <= mag_a_in;
          mag_b  <= mag_b_in;
          acc    <= {{WIDTH{1'b0}}, (Op[0] ? mag_a_in : mag_b_in)};
          rem    <= '0;
          cnt    <= CW'(WIDTH);
`ifdef MDU_SIGNED_EN
          neg_a   <= sa_in;
          neg_res <= sa_in ^ sb_in;
`endif
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt - CW'(1);
        end
        DIV: begin
          if (!div_diff[WIDTH]) begin
            rem <= div_diff;
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
          end else begin
            rem <= div_shift;
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          Done    <= 1'b1;
          DivZero <= op_div && (mag_b == '0);
          if (!op_div) begin
            Hi <= prod[2*WIDTH-1:WIDTH];
            Lo <= prod[WIDTH-1:0];
          end else if (mag_b == '0) begin
            Hi <= a_orig;
            Lo <= '1;
          end else begin
            Hi <= rmd;
            Lo <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
